// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the hazard controller and the 5-stage datapath.
// The controller takes the master modport and the datapath takes the slave modport.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             idex_memread;
  logic [4:0]       idex_rt;
  logic [4:0]       idex_rs;
  logic [4:0]       idex_rt_src;
  logic             exmem_regwrite;
  logic [4:0]       exmem_rd;
  logic             exmem_memacc;
  logic             exmem_pcsrc;
  logic             memwb_regwrite;
  logic [4:0]       memwb_rd;
  logic             mem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  ifid_rs, ifid_rt, idex_memread, idex_rt, idex_rs, idex_rt_src,
           exmem_regwrite, exmem_rd, exmem_memacc, exmem_pcsrc,
           memwb_regwrite, memwb_rd, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush,
           fwd_a, fwd_b, err_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    output ifid_rs, ifid_rt, idex_memread, idex_rt, idex_rs, idex_rt_src,
           exmem_regwrite, exmem_rd, exmem_memacc, exmem_pcsrc,
           memwb_regwrite, memwb_rd, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush,
           fwd_a, fwd_b, err_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes, load-use bubbles,
// branch squashes, data-memory wait states with timeout, and ALU forwarding selects.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.master hz
);
  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;
  localparam int              WC_W    = $clog2(MEM_TIMEOUT + 1);
  // The wait counter includes the current cycle, so release happens when it would hit MEM_TIMEOUT.
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       mem_stall;
  logic       load_use;
  logic       squash;
  logic       stall_inc;
  logic       flush_inc;
  logic [4:0] en_vec;     // {pc, ifid, idex, exmem, memwb}
  logic [2:0] flush_vec;  // {ifid, idex, exmem}

  assign load_use = hz.idex_memread && (hz.idex_rt != 5'd0) &&
                    ((hz.idex_rt == hz.ifid_rs) || (hz.idex_rt == hz.ifid_rt));
  assign squash   = hz.exmem_pcsrc;

  always_comb begin
    mem_stall  = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    if (state_q == RUN) begin
      if (hz.exmem_memacc && !hz.mem_ready) begin
        mem_stall  = 1'b1;
        state_d    = MEM_WAIT;
        wait_cnt_d = WC_W'(1);
      end
    end else begin
      if (!hz.mem_ready && (wait_cnt_q < WC_LAST)) begin
        mem_stall  = 1'b1;
        wait_cnt_d = wait_cnt_q + WC_W'(1);
      end else begin
        state_d    = RUN;
        wait_cnt_d = '0;
        if (!hz.mem_ready) err_d = 1'b1;
      end
    end
  end

  always_comb begin
    en_vec    = 5'b00000;
    flush_vec = 3'b000;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (!rst_n) begin
      en_vec    = 5'b00000;
    end else if (mem_stall) begin
      stall_inc = 1'b1;
    end else if (squash) begin
      en_vec    = 5'b11111;
      flush_vec = 3'b111;
      flush_inc = 1'b1;
    end else if (load_use) begin
      en_vec    = 5'b00111;
      flush_vec = 3'b010;
      stall_inc = 1'b1;
    end else begin
      en_vec    = 5'b11111;
    end
  end

  assign stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Operand forwarding; EX/MEM has precedence and register 0 never forwards.
  logic [1:0][4:0] fwd_src;
  logic [1:0][1:0] fwd_sel;
  assign fwd_src[0] = hz.idex_rs;
  assign fwd_src[1] = hz.idex_rt_src;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic ex_hit;
    logic wb_hit;
    assign ex_hit = hz.exmem_regwrite && (hz.exmem_rd != 5'd0) && (hz.exmem_rd == fwd_src[gi]);
    assign wb_hit = hz.memwb_regwrite && (hz.memwb_rd != 5'd0) && (hz.memwb_rd == fwd_src[gi]);
    assign fwd_sel[gi] = !rst_n ? 2'b00 : (ex_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00));
  end

  assign {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en} = en_vec;
  assign {hz.ifid_flush, hz.idex_flush, hz.exmem_flush}               = flush_vec;
  assign hz.fwd_a       = fwd_sel[0];
  assign hz.fwd_b       = fwd_sel[1];
  assign hz.err_timeout = err_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: length of the current memory-stall run, sticky error, event totals.
  int       m_wait_len;
  bit       m_err;
  int       m_stall;
  int       m_flush;
  bit       e_blk, e_tmo, e_lu;
  bit [4:0] e_en;
  bit [2:0] e_fl;

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (hz.exmem_regwrite && hz.exmem_rd != 0 && hz.exmem_rd == src) return 2'b10;
    if (hz.memwb_regwrite && hz.memwb_rd != 0 && hz.memwb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_en", {27'd0, hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en}, 0);
      chk("rst_cnt", {hz.stall_cnt, hz.flush_cnt}, 0);
      chk("rst_err", {31'd0, hz.err_timeout}, 0);
      m_wait_len = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_wait_len > 0) begin
        e_blk = !hz.mem_ready && (m_wait_len + 1 < MEM_TIMEOUT);
        e_tmo = !hz.mem_ready && !e_blk;
      end else begin
        e_blk = hz.exmem_memacc && !hz.mem_ready;
        e_tmo = 1'b0;
      end
      e_lu = hz.idex_memread && hz.idex_rt != 0 &&
             (hz.idex_rt == hz.ifid_rs || hz.idex_rt == hz.ifid_rt);
      if (e_blk)                 begin e_en = 5'b00000; e_fl = 3'b000; end
      else if (hz.exmem_pcsrc)   begin e_en = 5'b11111; e_fl = 3'b111; end
      else if (e_lu)             begin e_en = 5'b00111; e_fl = 3'b010; end
      else                       begin e_en = 5'b11111; e_fl = 3'b000; end

      chk("en", {27'd0, hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en}, {27'd0, e_en});
      chk("flush", {29'd0, hz.ifid_flush, hz.idex_flush, hz.exmem_flush}, {29'd0, e_fl});
      chk("fwd_a", {30'd0, hz.fwd_a}, {30'd0, exp_fwd(hz.idex_rs)});
      chk("fwd_b", {30'd0, hz.fwd_b}, {30'd0, exp_fwd(hz.idex_rt_src)});
      chk("err", {31'd0, hz.err_timeout}, {31'd0, m_err});
      chk("stall_cnt", {16'd0, hz.stall_cnt}, m_stall);
      chk("flush_cnt", {16'd0, hz.flush_cnt}, m_flush);
      $display("cyc %0d en=%b fl=%b fa=%b fb=%b stall=%0d flush=%0d err=%b",
               cyc, e_en, e_fl, hz.fwd_a, hz.fwd_b, hz.stall_cnt, hz.flush_cnt, hz.err_timeout);

      m_wait_len = e_blk ? m_wait_len + 1 : 0;
      if (e_tmo) m_err = 1'b1;
      if ((e_blk || (!hz.exmem_pcsrc && e_lu)) && m_stall < CNT_MAX) m_stall++;
      if (!e_blk && hz.exmem_pcsrc && m_flush < CNT_MAX) m_flush++;
    end
  end

  task automatic idle();
    hz.ifid_rs = 0; hz.ifid_rt = 0; hz.idex_memread = 0; hz.idex_rt = 0;
    hz.idex_rs = 0; hz.idex_rt_src = 0; hz.exmem_regwrite = 0; hz.exmem_rd = 0;
    hz.exmem_memacc = 0; hz.exmem_pcsrc = 0; hz.memwb_regwrite = 0; hz.memwb_rd = 0;
    hz.mem_ready = 1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  function automatic logic [31:0] en_now();
    return {27'd0, hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en};
  endfunction

  function automatic logic [31:0] fl_now();
    return {29'd0, hz.ifid_flush, hz.idex_flush, hz.exmem_flush};
  endfunction

  task automatic rand_cycle(input int ready_pct);
    hz.ifid_rs        = 5'($urandom_range(0, 3));
    hz.ifid_rt        = 5'($urandom_range(0, 3));
    hz.idex_memread   = ($urandom_range(0, 3) == 0);
    hz.idex_rt        = 5'($urandom_range(0, 3));
    hz.idex_rs        = 5'($urandom_range(0, 3));
    hz.idex_rt_src    = 5'($urandom_range(0, 3));
    hz.exmem_regwrite = 1'($urandom_range(0, 1));
    hz.exmem_rd       = 5'($urandom_range(0, 3));
    hz.exmem_memacc   = ($urandom_range(0, 2) == 0);
    hz.exmem_pcsrc    = ($urandom_range(0, 9) == 0);
    hz.memwb_regwrite = 1'($urandom_range(0, 1));
    hz.memwb_rd       = 5'($urandom_range(0, 3));
    hz.mem_ready      = ($urandom_range(0, 99) < ready_pct);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_en", en_now(), 0);
    chk("reset_fwd", {28'd0, hz.fwd_a, hz.fwd_b}, 0);
    chk("reset_cnt", {hz.stall_cnt, hz.flush_cnt}, 0);
    rst_n = 1'b1;

    step(); idle(); settle();
    chk("idle_en", en_now(), 32'h1F);
    chk("idle_flush", fl_now(), 0);
    chk("idle_stall", {16'd0, hz.stall_cnt}, 0);
    $display("directed: idle after reset");

    step(); hz.idex_memread = 1; hz.idex_rt = 8; hz.ifid_rs = 8; settle();
    chk("lu_en", en_now(), 32'h07);
    chk("lu_flush", fl_now(), 32'h2);
    step(); idle(); settle();
    chk("lu_after_en", en_now(), 32'h1F);
    chk("lu_stall_cnt", {16'd0, hz.stall_cnt}, 1);
    step(); hz.idex_memread = 1; hz.idex_rt = 0; hz.ifid_rs = 0; settle();
    chk("lu_r0_en", en_now(), 32'h1F);
    step(); idle(); settle();
    chk("lu_r0_stall", {16'd0, hz.stall_cnt}, 1);
    $display("directed: load-use");

    for (int i = 0; i < 3; i++) begin
      step(); hz.exmem_memacc = 1; hz.mem_ready = 0; settle();
      chk("mw_en", en_now(), 0);
    end
    step(); hz.mem_ready = 1; settle();
    chk("mw_resume_en", en_now(), 32'h1F);
    step(); idle(); settle();
    chk("mw_stall_cnt", {16'd0, hz.stall_cnt}, 4);
    chk("mw_err", {31'd0, hz.err_timeout}, 0);
    $display("directed: short memory wait");

    for (int i = 0; i < 20; i++) begin
      step(); hz.exmem_memacc = 1; hz.mem_ready = 0; settle();
      chk("to_en", en_now(), (i == MEM_TIMEOUT - 1) ? 32'h1F : 32'h0);
    end
    step(); hz.mem_ready = 1; settle();
    chk("to_release_en", en_now(), 32'h1F);
    step(); idle(); settle();
    chk("to_err", {31'd0, hz.err_timeout}, 1);
    chk("to_stall_cnt", {16'd0, hz.stall_cnt}, 23);
    $display("directed: memory timeout");

    step(); hz.exmem_pcsrc = 1; hz.idex_memread = 1; hz.idex_rt = 8; hz.ifid_rt = 8; settle();
    chk("br_en", en_now(), 32'h1F);
    chk("br_flush", fl_now(), 32'h7);
    step(); idle(); settle();
    chk("br_flush_after", fl_now(), 0);
    chk("br_flush_cnt", {16'd0, hz.flush_cnt}, 1);
    chk("br_stall_cnt", {16'd0, hz.stall_cnt}, 23);
    $display("directed: branch squash over load-use");

    step(); hz.idex_rs = 5; hz.exmem_rd = 5; hz.exmem_regwrite = 1; hz.memwb_rd = 5; hz.memwb_regwrite = 1;
    settle();
    chk("fwd_a_ex", {30'd0, hz.fwd_a}, 32'h2);
    step(); hz.exmem_regwrite = 0; settle();
    chk("fwd_a_wb", {30'd0, hz.fwd_a}, 32'h1);
    step(); hz.idex_rt_src = 0; hz.exmem_rd = 0; hz.exmem_regwrite = 1; hz.memwb_rd = 0; settle();
    chk("fwd_b_r0", {30'd0, hz.fwd_b}, 0);
    $display("directed: forwarding");

    for (int i = 0; i < 800; i++) begin step(); rand_cycle(50); end
    for (int i = 0; i < 800; i++) begin step(); rand_cycle(4); end
    $display("random phases done");

    for (int i = 0; i < 3; i++) begin
      step(); idle(); hz.exmem_memacc = 1; hz.mem_ready = 0;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", en_now(), 0);
    chk("arst_cnt", {hz.stall_cnt, hz.flush_cnt}, 0);
    chk("arst_err", {31'd0, hz.err_timeout}, 0);
    repeat (2) @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    settle();
    chk("post_rst_en", en_now(), 32'h1F);
    chk("post_rst_cnt", {hz.stall_cnt, hz.flush_cnt}, 0);
    chk("post_rst_err", {31'd0, hz.err_timeout}, 0);
    $display("directed: async reset during memory wait");

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
